// File: rtl/uart_rx_pkg.sv
// UART RX shared types, default widths and stop-bit config clamp.
// Used by the stop checker and reusable status counters.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DONE
  } stop_state_e;

  localparam int unsigned DEF_MAX_STOP_BITS = 2;
  localparam int unsigned DEF_STOP_CFG_W    = 2;
  localparam int unsigned DEF_ERR_CNT_W     = 8;

  function automatic int unsigned clamp_stop_cfg(
    input int unsigned cfg,
    input int unsigned max_bits
  );
    if (cfg == 0) return 1;
    if (cfg > max_bits) return max_bits;
    return cfg;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins).
// Shared by framing/parity/overrun status counters.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // next count: clear first, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/uart_stop_checker.sv
// UART RX stop-bit checker: validates 1..MAX_STOP_BITS stop bits.
// STOP_EARLY_EXIT_EN: first 0 stop sample ends the window at once.
module uart_stop_checker
  import uart_rx_pkg::*;
#(
  parameter int unsigned MAX_STOP_BITS = DEF_MAX_STOP_BITS,
  parameter int unsigned STOP_CFG_W    = DEF_STOP_CFG_W,
  parameter int unsigned ERR_CNT_W     = DEF_ERR_CNT_W
) (
  input  logic                  clk,
  input  logic                  stop_rst,
  input  logic                  stop_check_en,
  input  logic                  sample_valid,
  input  logic                  sampled_bit,
  input  logic [STOP_CFG_W-1:0] stop_bits_cfg,
  input  logic                  err_clr,
  output logic                  stop_err,
  output logic                  stop_done,
  output logic [ERR_CNT_W-1:0]  err_count
);

  stop_state_e           state_q, state_d;
  logic [STOP_CFG_W-1:0] cfg_q, cfg_d;
  logic [STOP_CFG_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                  stop_err_q, stop_err_d;
  logic                  armed_q, armed_d;
  logic                  err_inc;

  // next state, frame bookkeeping and done strobe
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_err_d = stop_err_q;
    armed_d    = armed_q;
    err_inc    = 1'b0;
    stop_done  = 1'b0;
    if (!stop_check_en) begin
      armed_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (stop_check_en && armed_q) begin
          state_d    = ST_CHECK;
          cfg_d      = STOP_CFG_W'(clamp_stop_cfg(
                         32'(stop_bits_cfg), MAX_STOP_BITS));
          bit_cnt_d  = '0;
          stop_err_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (!stop_check_en) begin
          state_d    = ST_IDLE;
          stop_err_d = 1'b0;
        end else if (sample_valid) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (!sampled_bit) begin
            stop_err_d = 1'b1;
          end
          if (bit_cnt_d == cfg_q) begin
            state_d = ST_DONE;
          end
`ifdef STOP_EARLY_EXIT_EN
          if (!sampled_bit) begin
            state_d = ST_DONE;
          end
`else
`endif
        end
      end
      ST_DONE: begin
        stop_done = 1'b1;
        err_inc   = stop_err_q;
        state_d   = ST_IDLE;
        if (stop_check_en) begin
          armed_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and frame registers
  always_ff @(posedge clk or negedge stop_rst) begin
    if (!stop_rst) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      bit_cnt_q  <= '0;
      stop_err_q <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_err_q <= stop_err_d;
      armed_q    <= armed_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (stop_rst),
    .inc   (err_inc),
    .clr   (err_clr),
    .count (err_count)
  );

  assign stop_err = stop_err_q;

endmodule

// File: tb/tb_uart_stop_checker.sv
// Randomized frame-level bench for uart_stop_checker.
// Expected results come from a per-frame model of the stop rules.
module tb_uart_stop_checker;

  localparam int MAX = 2;
  localparam int CW  = 2;
  localparam int EW  = 2;
  localparam int SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          stop_rst;
  logic          en;
  logic          sv;
  logic          sb;
  logic [CW-1:0] cfg;
  logic          clr;
  logic          stop_err;
  logic          stop_done;
  logic [EW-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  bit exp_err  = 1'b0;

  always #5 clk = ~clk;

  uart_stop_checker #(
    .MAX_STOP_BITS (MAX),
    .STOP_CFG_W    (CW),
    .ERR_CNT_W     (EW)
  ) dut (
    .clk           (clk),
    .stop_rst      (stop_rst),
    .stop_check_en (en),
    .sample_valid  (sv),
    .sampled_bit   (sb),
    .stop_bits_cfg (cfg),
    .err_clr       (clr),
    .stop_err      (stop_err),
    .stop_done     (stop_done),
    .err_count     (err_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_cfg(input int c);
    if (c == 0) return 1;
    if (c > MAX) return MAX;
    return c;
  endfunction

  function automatic int cnt_after(input int c, input bit e,
                                   input bit cl);
    if (cl) return 0;
    if (e && c < SAT) return c + 1;
    return c;
  endfunction

  // pat < 0: random stop bits; else bit i of pat is sample i
  task automatic run_frame(input int c, input bit abort,
                           input int pat, input bit fclr);
    bit bits[$];
    int eff, k, n, gaps;
    bit err, dclr;
    eff = eff_cfg(c);
    for (int i = 0; i < eff; i++) begin
      if (pat < 0) bits.push_back($urandom_range(2) != 0);
      else         bits.push_back(pat[i]);
    end
    k   = eff;
    err = 1'b0;
    for (int i = 0; i < eff; i++) begin
      if (!bits[i]) begin
        err = 1'b1;
`ifdef STOP_EARLY_EXIT_EN
        k = i + 1;
        break;
`endif
      end
    end
    n = abort ? int'($urandom_range(k - 1)) : k;

    en  = 1'b0;
    sv  = 1'b0;
    cfg = CW'($urandom);
    clr = ($urandom_range(7) == 0);
    tick;
    exp_cnt = cnt_after(exp_cnt, 1'b0, clr);
    clr = 1'b0;
    check("idle_done", stop_done, 0);
    check("idle_cnt", err_count, exp_cnt);
    check("idle_err_hold", stop_err, exp_err);

    en  = 1'b1;
    cfg = CW'(c);
    sv  = $urandom_range(1);
    sb  = 1'b0;
    tick;
    exp_err = 1'b0;
    check("entry_err", stop_err, 0);
    check("entry_done", stop_done, 0);

    for (int s = 0; s < n; s++) begin
      gaps = $urandom_range(2);
      repeat (gaps) begin
        sv  = 1'b0;
        cfg = CW'($urandom);
        tick;
        check("gap_done", stop_done, 0);
      end
      sv = 1'b1;
      sb = bits[s];
      tick;
      sv = 1'b0;
      if (!abort && s == k - 1) begin
        exp_err = err;
        check("done", stop_done, 1);
        check("done_err", stop_err, err);
        check("done_cnt", err_count, exp_cnt);
        dclr = fclr || ($urandom_range(5) == 0);
        clr  = dclr;
        sv   = $urandom_range(1);
        sb   = 1'b0;
        tick;
        clr  = 1'b0;
        exp_cnt = cnt_after(exp_cnt, err, dclr);
        check("post_done", stop_done, 0);
        check("post_cnt", err_count, exp_cnt);
        check("post_err", stop_err, err);
        repeat ($urandom_range(2)) begin
          sv = $urandom_range(1);
          sb = $urandom_range(1);
          tick;
          check("no_reenter", stop_done, 0);
        end
        sv = 1'b0;
      end else begin
        check("mid_done", stop_done, 0);
      end
    end

    if (abort) begin
      en = 1'b0;
      sv = $urandom_range(1);
      sb = 1'b0;
      tick;
      sv = 1'b0;
      exp_err = 1'b0;
      check("abort_done", stop_done, 0);
      check("abort_err", stop_err, 0);
      tick;
      check("abort_done2", stop_done, 0);
      check("abort_cnt", err_count, exp_cnt);
    end
  endtask

  initial begin
    stop_rst = 1'b0;
    en  = 1'b0;
    sv  = 1'b0;
    sb  = 1'b1;
    cfg = '0;
    clr = 1'b0;
    repeat (2) tick;
    check("rst_err", stop_err, 0);
    check("rst_done", stop_done, 0);
    check("rst_cnt", err_count, 0);
    stop_rst = 1'b1;
    tick;

    run_frame(2, 1'b0, 0, 1'b0);
    en = 1'b0;
    tick;
    en  = 1'b1;
    cfg = CW'(2);
    tick;
    sv = 1'b1;
    sb = 1'b0;
    tick;
    sv = 1'b0;
    #2;
    stop_rst = 1'b0;
    en = 1'b0;
    #1;
    check("arst_err", stop_err, 0);
    check("arst_done", stop_done, 0);
    check("arst_cnt", err_count, 0);
    exp_cnt = 0;
    exp_err = 1'b0;
    tick;
    check("arst_done2", stop_done, 0);
    stop_rst = 1'b1;
    tick;

    run_frame(1, 1'b0, 1, 1'b0);
    run_frame(2, 1'b0, 32'b01, 1'b0);
    run_frame(2, 1'b0, 32'b10, 1'b0);
    run_frame(2, 1'b1, 3, 1'b0);
    run_frame(0, 1'b0, 0, 1'b0);
    run_frame(3, 1'b0, 32'b01, 1'b0);
    run_frame(3, 1'b0, 3, 1'b0);
    repeat (5) run_frame(2, 1'b0, 0, 1'b0);
    check("sat_cnt", err_count, SAT);
    run_frame(1, 1'b0, 0, 1'b1);
    check("clr_in_done", err_count, 0);

    for (int f = 0; f < 300; f++) begin
      run_frame(int'($urandom_range(3)),
                ($urandom_range(3) == 0), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
